// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-high key matrix scanner.
// Drives one row at a time with a blanking gap at the start of every row
// slot, samples the synchronized columns at the end of the slot, and
// debounces whole 16-bit frames. One strobe is issued per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 8192,
    parameter int SETTLE         = 100,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [3:0] col_in,
    output logic [3:0] row_sel,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    output logic       o_key_held,
    output logic       o_multi_key
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SETTLE - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;

    // Column synchronizer
    logic [3:0] col_m_q;
    logic [3:0] col_s_q;

    // Scan timing
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       ridx_q;
    logic [3:0]       row_sel_q;
    logic             started_q;
    logic             sample_en;

    // Frame capture
    logic [11:0] frame_acc_q;
    logic [15:0] frame_q;
    logic        frame_done_q;

    // Frame classification
    logic [4:0] nkeys;
    logic [3:0] key_idx;

    // Debounce FSM and outputs
    logic [1:0]      state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [DB_W-1:0] stab_q, stab_d;
    logic [DB_W-1:0] rel_q, rel_d;
    logic            valid_q, valid_d;
    logic [3:0]      code_q, code_d;
    logic            held_q, held_d;
    logic            multi_q, multi_d;
    logic            accept;

    // Two-flop synchronizer; keeps running while the scan is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m_q <= 4'd0;
            col_s_q <= 4'd0;
        end else begin
            col_m_q <= col_in;
            col_s_q <= col_m_q;
        end
    end

    // Slot counter, row index and registered row drive. The first enabled
    // edge after reset/disable behaves as a slot wrap, so row 0 comes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ridx_q    <= 2'd3;
            row_sel_q <= 4'd0;
            started_q <= 1'b0;
        end else if (!i_en) begin
            cnt_q     <= '0;
            ridx_q    <= 2'd3;
            row_sel_q <= 4'd0;
            started_q <= 1'b0;
        end else if (!started_q || cnt_q == CNT_LAST) begin
            cnt_q     <= '0;
            ridx_q    <= ridx_q + 2'd1;
            row_sel_q <= 4'd0;
            started_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_PRE) begin
                row_sel_q <= 4'b0001 << ridx_q;
            end
        end
    end

    assign sample_en = started_q && (cnt_q == CNT_LAST);

    // Column sampling at slot end; the row-3 sample completes the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_acc_q  <= 12'd0;
            frame_q      <= 16'd0;
            frame_done_q <= 1'b0;
        end else if (!i_en) begin
            frame_acc_q  <= 12'd0;
            frame_q      <= 16'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (sample_en) begin
                if (ridx_q == 2'd3) begin
                    frame_q      <= {col_s_q, frame_acc_q};
                    frame_done_q <= 1'b1;
                end else begin
                    for (int r = 0; r < 3; r++) begin
                        if (ridx_q == 2'(r)) begin
                            frame_acc_q[r*4 +: 4] <= col_s_q;
                        end
                    end
                end
            end
        end
    end

    // Popcount of the completed frame plus the index of a set key.
    always_comb begin
        nkeys   = 5'd0;
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_q[i]) begin
                nkeys   = nkeys + 5'd1;
                key_idx = 4'(i);
            end
        end
    end

    // Debounce FSM; only advances on frame_done.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        stab_d  = stab_q;
        rel_d   = rel_q;
        valid_d = 1'b0;
        code_d  = code_q;
        held_d  = held_q;
        multi_d = multi_q;
        accept  = 1'b0;
        if (frame_done_q) begin
            multi_d = (nkeys > 5'd1);
            case (state_q)
                ST_IDLE: begin
                    if (nkeys == 5'd1) begin
                        cand_d = key_idx;
                        stab_d = DB_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (nkeys == 5'd1) begin
                        if (key_idx == cand_q) begin
                            stab_d = stab_q + DB_W'(1);
                            if (stab_q + DB_W'(1) == DB_MAX) begin
                                accept = 1'b1;
                            end
                        end else begin
                            cand_d = key_idx;
                            stab_d = DB_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (nkeys == 5'd0) begin
                        rel_d = rel_q + DB_W'(1);
                        if (rel_q + DB_W'(1) == DB_MAX) begin
                            held_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (accept) begin
                valid_d = 1'b1;
                code_d  = cand_d;
                held_d  = 1'b1;
                rel_d   = '0;
                state_d = ST_PRESSED;
            end
        end
    end

    // FSM and output registers; disable clears everything and wins over a
    // coincident frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cand_q  <= 4'd0;
            stab_q  <= '0;
            rel_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 4'd0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
        end else if (!i_en) begin
            state_q <= ST_IDLE;
            cand_q  <= 4'd0;
            stab_q  <= '0;
            rel_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 4'd0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            rel_q   <= rel_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            held_q  <= held_d;
            multi_q <= multi_d;
        end
    end

    assign row_sel     = row_sel_q;
    assign o_key_valid = valid_q;
    assign o_key_code  = code_q;
    assign o_key_held  = held_q;
    assign o_multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a small-parameter instance.
module tb_keypad_scanner;

    localparam int SD = 16;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_n;
    logic       i_en;
    logic [3:0] col_in;
    logic [3:0] row_sel;
    logic       o_key_valid;
    logic [3:0] o_key_code;
    logic       o_key_held;
    logic       o_multi_key;

    logic [15:0] keys = 16'd0;
    logic [3:0]  exp_q [$];
    int checks = 0;
    int failures = 0;

    keypad_scanner #(.SCAN_DIV(16), .SETTLE(2), .DEBOUNCE_SCANS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (i_en),
        .col_in     (col_in),
        .row_sel    (row_sel),
        .o_key_valid(o_key_valid),
        .o_key_code (o_key_code),
        .o_key_held (o_key_held),
        .o_multi_key(o_multi_key)
    );

    always #5 if (clk_run) clk = ~clk;

    // Key matrix model: a column is high if any pressed key in a driven row sits on it.
    always_comb begin
        col_in = 4'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && row_sel[r]) col_in[c] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected code.
    always @(negedge clk) begin
        if (rst_n && o_key_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got code %0d expected none at %0t", o_key_code, $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (o_key_code !== e) begin
                    failures++;
                    $display("FAIL strobe_code: got %0d expected %0d at %0t", o_key_code, e, $time);
                end else begin
                    $display("strobe code=%0d at %0t", o_key_code, $time);
                end
            end
        end
    end

    task automatic step_frames(input int n);
        repeat (n * FRAME) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the first driven row; it must be row 0.
    task automatic wait_row0(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (row_sel != 4'd0) break;
        end
        chk(name, {28'd0, row_sel}, 32'd1);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_row_sel"}, {28'd0, row_sel}, 32'd0);
        chk({tag, "_valid"}, {31'd0, o_key_valid}, 32'd0);
        chk({tag, "_code"}, {28'd0, o_key_code}, 32'd0);
        chk({tag, "_held"}, {31'd0, o_key_held}, 32'd0);
        chk({tag, "_multi"}, {31'd0, o_multi_key}, 32'd0);
    endtask

    task automatic chk_no_pending(input string name);
        chk(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_en = 1'b1;

        // 1: row pattern with no keys.
        wait_row0("first_row");
        for (int i = 0; i < 2 * FRAME; i++) begin
            int cv, slot;
            logic [3:0] e;
            cv   = (2 + i) % SD;
            slot = ((2 + i) / SD) % 4;
            e = (cv < 2) ? 4'd0 : (4'b0001 << slot);
            chk("row_pattern", {28'd0, row_sel}, {28'd0, e});
            chk("idle_outs", {28'd0, o_key_valid, o_key_held, o_multi_key, 1'b0}, 32'd0);
            @(posedge clk);
            #1;
        end

        // 2: key (1,2) for 4 frames, then released for 3.
        keys = 16'd1 << 6;
        exp_q.push_back(4'd6);
        step_frames(1);
        chk("t2_held_f1", {31'd0, o_key_held}, 32'd0);
        step_frames(1);
        chk("t2_held_f2", {31'd0, o_key_held}, 32'd1);
        chk_no_pending("t2_strobe_seen");
        step_frames(2);
        chk("t2_held_f4", {31'd0, o_key_held}, 32'd1);
        keys = 16'd0;
        step_frames(1);
        chk("t2_held_rel1", {31'd0, o_key_held}, 32'd1);
        step_frames(1);
        chk("t2_held_rel2", {31'd0, o_key_held}, 32'd0);
        step_frames(1);
        chk("t2_code_hold", {28'd0, o_key_code}, 32'd6);

        // 3: bounce on key 9, then 9 -> 5 -> 5.
        keys = 16'd1 << 9;
        step_frames(1);
        keys = 16'd0;
        step_frames(1);
        chk("t3_bounce_held", {31'd0, o_key_held}, 32'd0);
        keys = 16'd1 << 9;
        step_frames(1);
        keys = 16'd1 << 5;
        exp_q.push_back(4'd5);
        step_frames(2);
        chk_no_pending("t3_strobe_seen");
        chk("t3_code", {28'd0, o_key_code}, 32'd5);
        keys = 16'd0;
        step_frames(2);
        chk("t3_released", {31'd0, o_key_held}, 32'd0);

        // 4: keys 3 and 12 together, then 12 released.
        keys = (16'd1 << 3) | (16'd1 << 12);
        step_frames(1);
        chk("t4_multi_f1", {31'd0, o_multi_key}, 32'd1);
        step_frames(2);
        chk("t4_multi_f3", {31'd0, o_multi_key}, 32'd1);
        chk("t4_no_press", {31'd0, o_key_held}, 32'd0);
        keys = 16'd1 << 3;
        exp_q.push_back(4'd3);
        step_frames(1);
        chk("t4_multi_clear", {31'd0, o_multi_key}, 32'd0);
        step_frames(1);
        chk_no_pending("t4_strobe_seen");
        chk("t4_code", {28'd0, o_key_code}, 32'd3);
        keys = 16'd0;
        step_frames(2);
        chk("t4_released", {31'd0, o_key_held}, 32'd0);

        // 5: key 0 accepted, disable, re-enable with key still held.
        keys = 16'd1;
        exp_q.push_back(4'd0);
        step_frames(2);
        chk_no_pending("t5_strobe_seen");
        chk("t5_held", {31'd0, o_key_held}, 32'd1);
        i_en = 1'b0;
        @(posedge clk);
        #1;
        chk_outs_zero("t5_disabled");
        repeat (9) @(posedge clk);
        #1;
        i_en = 1'b1;
        exp_q.push_back(4'd0);
        wait_row0("t5_restart_row");
        step_frames(2);
        chk_no_pending("t5_restrobe_seen");
        chk("t5_reheld", {31'd0, o_key_held}, 32'd1);
        keys = 16'd0;
        step_frames(2);

        // 6: asynchronous reset with the clock stopped mid-slot.
        repeat (5) @(posedge clk);
        @(negedge clk);
        clk_run = 1'b0;
        #2;
        chk("t6_row_before", {31'd0, row_sel != 4'd0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_outs_zero("t6_async_reset");
        #3;
        rst_n = 1'b1;
        #4;
        clk_run = 1'b1;
        wait_row0("t6_restart_row");

        repeat (5) @(posedge clk);
        #1;
        chk_no_pending("final_no_pending");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
